// File: rtl/seq_mult_core.sv
// seq_mult_core: sequential signed-magnitude shift-and-add multiplier.
// The operands are captured as unsigned magnitudes plus sign bits. The
// core produces |A|*|B| one multiplier bit per RUN cycle. o_stop is a
// one-cycle pulse that drives the downstream complement stage.
// Optional feature: define SEQ_MULT_EARLY_TERM_EN to end RUN as soon as
// the remaining multiplier bits are all zero. The product value is the
// same in both builds; only the latency changes.
module seq_mult_core #(
    parameter int DW = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [DW-1:0]   i_a,
    input  logic [DW-1:0]   i_b,
    output logic [2*DW-1:0] o_product,
    output logic            o_signA,
    output logic            o_signB,
    output logic            o_stop,
    output logic            o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(DW + 1);

    state_t          state;
    state_t          state_nxt;
    logic [2*DW-1:0] acc;
    logic [2*DW-1:0] mcand;
    logic [DW-1:0]   mplier;
    logic [CW-1:0]   cnt;
    logic            sign_a;
    logic            sign_b;
    logic            stop_q;

    logic [DW-1:0]   mag_a;
    logic [DW-1:0]   mag_b;
    logic [DW-1:0]   mplier_shr;
    logic            last_cycle;

    // Two's-complement magnitude of each operand. The result is held in DW
    // unsigned bits, so -2^(DW-1) maps to 2^(DW-1) with no overflow.
    always_comb begin
        mag_a = i_a[DW-1] ? (~i_a) + DW'(1) : i_a;
        mag_b = i_b[DW-1] ? (~i_b) + DW'(1) : i_b;
    end

    // Detect the final RUN cycle. The full build always runs DW cycles.
    // The early-terminating build also stops once the shifted multiplier is empty.
    always_comb begin
        mplier_shr = mplier >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
        last_cycle = (cnt == CW'(DW - 1)) || (mplier_shr == '0);
`else
        last_cycle = (cnt == CW'(DW - 1));
`endif
    end

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
    // NOTE: every combinational output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = RUN;
            RUN:     if (last_cycle) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register. Reset forces IDLE at once, even in the middle of RUN.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge, whatever order the
    // statements are written in.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath: operand capture in IDLE, then one shift-and-add step per RUN cycle.
    // The accumulator is 2*DW bits and |A|*|B| <= 2^(2*DW-2), so it cannot overflow.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        acc    <= '0;
                        mcand  <= {{DW{1'b0}}, mag_a};
                        mplier <= mag_b;
                        cnt    <= '0;
                        sign_a <= i_a[DW-1];
                        sign_b <= i_b[DW-1];
                    end
                end
                RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier_shr;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // o_stop is registered out of DONE. It therefore pulses exactly one cycle
    // on the edge after the last RUN step, once the accumulator has settled.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) stop_q <= 1'b0;
        else        stop_q <= (state == DONE);
    end

    // The result and sign outputs come straight from the capture/accumulate
    // registers. They stay stable from DONE until the next accepted start.
    assign o_product = acc;
    assign o_signA   = sign_a;
    assign o_signB   = sign_b;
    assign o_stop    = stop_q;
    assign o_busy    = (state == RUN);

endmodule
